// File: rtl/icache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_arb_pkg
// Brief    : Shared constants, age counter type and one-hot decode helper for
//            the icache front-end request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package icache_arb_pkg;

    // Channel assignment at the icache front end
    localparam int CH_CPU   = 0;
    localparam int CH_INV   = 1;
    localparam int CH_PF    = 2;

    // Largest supported channel count; sizes the one-hot decode helper
    localparam int MAX_REQS = 16;

    // Per-channel wait-age counter, saturating at its all-ones value
    localparam int AGE_W    = 8;
    typedef logic [AGE_W-1:0] age_t;
    localparam age_t AGE_MAX = '1;

    // One-hot (or zero) vector to binary index; a zero vector decodes to 0
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQS; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : icache_rr_pick
// Brief    : Combinational masked priority picker. Returns the first set
//            request at or above the start pointer, wrapping to the lowest
//            set request when none exist above it.
// Revision : 1.0 - initial release
// ============================================================================
module icache_rr_pick #(
    parameter int NUM_REQS = 3,
    parameter int ID_W     = 2
) (
    input  logic [NUM_REQS-1:0] req_i,
    input  logic [ID_W-1:0]     ptr_i,
    output logic [NUM_REQS-1:0] gnt_o,
    output logic                valid_o
);

    logic [NUM_REQS-1:0]   w_mask;
    logic [2*NUM_REQS-1:0] w_dbl;
    logic [2*NUM_REQS-1:0] w_low;

    // Thermometer mask selecting channel indices at or above the pointer
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_mask[i] = (i >= int'(ptr_i));
        end
    end

    // Lower half holds the masked requests, upper half the full set; isolating
    // the lowest set bit of the concatenation yields the wrap-around winner.
    assign w_dbl   = {req_i, req_i & w_mask};
    assign w_low   = w_dbl & (-w_dbl);
    assign gnt_o   = w_low[NUM_REQS-1:0] | w_low[2*NUM_REQS-1:NUM_REQS];
    assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/icache_req_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : icache_req_arb_rr
// Brief    : N-channel valid/ready request arbiter with fixed-priority or
//            round-robin selection, age-based starvation promotion and a
//            single-entry full-throughput output register.
// Revision : 1.0 - initial release
// ============================================================================
module icache_req_arb_rr
    import icache_arb_pkg::*;
#(
    parameter int NUM_REQS     = 3,
    parameter int DATA_W       = 64,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 8,
    parameter int ID_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQS-1:0]        in_valid,
    output logic [NUM_REQS-1:0]        in_ready,
    input  logic [NUM_REQS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_starved,
    output logic                       busy
);

    localparam age_t            STARVE_TH = age_t'(STARVE_LIMIT);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQS - 1);
    localparam logic [ID_W-1:0] PTR_FIXED = ID_W'(CH_CPU);

    logic                out_valid_q,   out_valid_d;
    logic [DATA_W-1:0]   out_data_q,    out_data_d;
    logic [ID_W-1:0]     out_id_q,      out_id_d;
    logic                out_starved_q, out_starved_d;
    logic [ID_W-1:0]     rr_ptr_q,      rr_ptr_d;
    age_t                age_q [NUM_REQS];
    age_t                age_d [NUM_REQS];

    logic [NUM_REQS-1:0] w_starve_req;
    logic [NUM_REQS-1:0] w_starve_gnt;
    logic                w_starve_any;
    logic [NUM_REQS-1:0] w_main_gnt;
    logic                w_main_any;
    logic [ID_W-1:0]     w_main_ptr;
    logic [NUM_REQS-1:0] w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_load;
    logic                w_xfer;

    // Channels whose wait age has reached the promotion threshold
    always_comb begin
        w_starve_req = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_starve_req[i] = (STARVE_LIMIT != 0) && in_valid[i] &&
                              (age_q[i] >= STARVE_TH);
        end
    end

    // Starved channels are served lowest index first
    icache_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .ID_W     (ID_W)
    ) u_pick_starve (
        .req_i    (w_starve_req),
        .ptr_i    ('0),
        .gnt_o    (w_starve_gnt),
        .valid_o  (w_starve_any)
    );

    // Normal path: fixed priority starts at channel 0, round-robin at the pointer
    assign w_main_ptr = (RR_MODE != 0) ? rr_ptr_q : PTR_FIXED;

    icache_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .ID_W     (ID_W)
    ) u_pick_main (
        .req_i    (in_valid),
        .ptr_i    (w_main_ptr),
        .gnt_o    (w_main_gnt),
        .valid_o  (w_main_any)
    );

    assign w_gnt    = w_starve_any ? w_starve_gnt : w_main_gnt;
    assign w_idx    = ID_W'(onehot_to_idx(MAX_REQS'(w_gnt)));
    assign w_load   = ~out_valid_q | out_ready;
    assign w_xfer   = w_load & w_main_any;
    assign in_ready = w_load ? w_gnt : '0;

    // Output register refill / drain and round-robin pointer advance
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_id_d      = out_id_q;
        out_starved_d = out_starved_q;
        rr_ptr_d      = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = in_data[w_idx*DATA_W +: DATA_W];
            out_id_d      = w_idx;
            out_starved_d = w_starve_any;
            rr_ptr_d      = (w_idx == LAST_IDX) ? '0 : w_idx + ID_W'(1);
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    // Age counters: reset when idle or accepted, otherwise count waiting cycles
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!in_valid[i] || in_ready[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + age_t'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_id_q      <= '0;
            out_starved_q <= 1'b0;
            rr_ptr_q      <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_id_q      <= out_id_d;
            out_starved_q <= out_starved_d;
            rr_ptr_q      <= rr_ptr_d;
            for (int i = 0; i < NUM_REQS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign out_starved = out_starved_q;
    assign busy        = out_valid_q | (|in_valid);

endmodule
`default_nettype wire
